// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block: FSM state encoding,
// default parameter values and a one-hot helper.
package decoder_pkg;

  localparam int DEF_SEL_W   = 3;
  localparam int DEF_DWELL_W = 4;
  localparam int MAX_SEL_W   = 6;
  localparam int MAX_N       = 2 ** MAX_SEL_W;

  // 2'd3 is never entered; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // Full-width one-hot of an index; callers size-cast down to their N.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] index);
    onehot        = '0;
    onehot[index] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-N decoder with enable; all-zero when en is low.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter  int SEL_W = DEF_SEL_W,
  localparam int N     = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] index,
  input  logic             en,
  output logic [N-1:0]     dec
);

  // Decode through the shared helper, truncated to this instance's width.
  always_comb begin
    dec = en ? N'(onehot(MAX_SEL_W'(index))) : '0;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT and SCAN modes.
// DIRECT registers onehot(sel); SCAN steps the active bit through all N
// positions holding each for dwell+1 cycles, pulsing wrap on roll-over.
// Optional build macro DECODER_SCAN_DIR_EN adds a `dir` input that
// reverses the scan direction (wrap then marks the 0 -> N-1 step).
//
// Handshake: there is no back-pressure. valid is a registered qualifier
// for out/idx; whenever valid is 1 the out/idx pair is meaningful that
// cycle, and it is never stalled by the consumer.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = DEF_SEL_W,
  parameter  int DWELL_W = DEF_DWELL_W,
  localparam int N       = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_DIR_EN
  input  logic               dir,
`endif
  output logic [N-1:0]       out,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  localparam logic [SEL_W-1:0]   IDX_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(N - 1);
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       out_q, out_d;
  logic               valid_q;

  // Next state, next index, dwell counter and wrap pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          idx_d = sel;
          if (mode) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end else begin
            state_d = ST_DIRECT;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            state_d = ST_DIRECT;
            idx_d   = sel;
          end else if (cnt_q >= dwell) begin
            // >= lets a dwell shrunk below cnt advance at once.
            cnt_d = '0;
`ifdef DECODER_SCAN_DIR_EN
            if (dir) begin
              idx_d  = idx_q - IDX_ONE;
              wrap_d = (idx_q == '0);
            end else begin
              idx_d  = idx_q + IDX_ONE;
              wrap_d = (idx_q == IDX_LAST);
            end
`else
            idx_d  = idx_q + IDX_ONE;
            wrap_d = (idx_q == IDX_LAST);
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
    .index (idx_d),
    .en    (state_d != ST_IDLE),
    .dec   (out_d)
  );

  // State and output registers, all loaded from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
      valid_q <= (state_d != ST_IDLE);
    end
  end

  assign out   = out_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan (SEL_W=3, DWELL_W=4): directed vectors with
// hand-computed expectations, scoreboard queue and a cycle monitor.
module tb_decoder_scan;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;
  localparam int N       = 8;
  localparam int W       = N + SEL_W + 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic               dir;
  logic               dir_val;
  logic [N-1:0]       out;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  int           sc_idx[9] = '{6, 6, 7, 7, 7, 0, 0, 0, 1};

  decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .dwell (dwell),
`ifdef DECODER_SCAN_DIR_EN
    .dir   (dir),
`endif
    .out   (out),
    .idx   (idx),
    .valid (valid),
    .wrap  (wrap)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs and queue the response after the edge.
  task automatic step(input logic e, input logic m, input logic [SEL_W-1:0] s,
                      input logic [DWELL_W-1:0] d, input logic v,
                      input logic [SEL_W-1:0] ei, input logic w, input string nm);
    logic [N-1:0] eo;
    @(negedge clk);
    en    = e;
    mode  = m;
    sel   = s;
    dwell = d;
    dir   = dir_val;
    eo    = v ? (8'd1 << ei) : 8'd0;
    exp_q.push_back({eo, ei, v, w});
    name_q.push_back(nm);
  endtask

  // Immediate check against the all-zero reset values.
  task automatic check_reset(input string nm);
    n_vec++;
    if ({out, idx, valid, wrap} !== '0) begin
      n_miss++;
      $display("FAIL %s: out=%b idx=%0d valid=%b wrap=%b, required all zero",
               nm, out, idx, valid, wrap);
    end
  endtask

  // Monitor / scoreboard: compare each registered response after the edge.
  initial begin
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if ({out, idx, valid, wrap} !== e) begin
          n_miss++;
          $display("FAIL %s: got out=%b idx=%0d valid=%b wrap=%b, want out=%b idx=%0d valid=%b wrap=%b",
                   nm, out, idx, valid, wrap,
                   e[W-1 -: N], e[SEL_W+1 -: SEL_W], e[1], e[0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;
    dir = 1'b0; dir_val = 1'b0;
    #12;
    check_reset("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // DIRECT
    step(1, 0, 3'd5, 4'd0, 1, 3'd5, 0, "direct_sel5");
    step(1, 0, 3'd0, 4'd0, 1, 3'd0, 0, "direct_sel0");

    // SCAN from 6 with dwell 2; sel changes mid-scan are ignored
    step(1, 1, 3'd6, 4'd2, 1, 3'd6, 0, "scan_entry_sel6");
    for (int i = 0; i < 9; i++)
      step(1, 1, 3'd3, 4'd2, 1, 3'(sc_idx[i]), (i == 5), "scan_dwell2");

    // en priority, IDLE held with mode=1, restart at current sel
    step(0, 1, 3'd3, 4'd2, 0, 3'd1, 0, "en_off");
    step(0, 1, 3'd3, 4'd2, 0, 3'd1, 0, "en_off_hold");
    step(1, 1, 3'd2, 4'd0, 1, 3'd2, 0, "scan_restart_sel2");

    // Entry at 0 (no wrap) then dwell 0 steps every cycle
    step(0, 1, 3'd0, 4'd0, 0, 3'd2, 0, "en_off2");
    step(1, 1, 3'd0, 4'd0, 1, 3'd0, 0, "scan_entry_sel0");
    for (int i = 1; i <= 16; i++)
      step(1, 1, 3'd0, 4'd0, 1, 3'(i % 8), ((i % 8) == 0), "scan_dwell0");

    // Live dwell shrink below current count
    step(1, 0, 3'd4, 4'd9, 1, 3'd4, 0, "direct_sel4");
    step(1, 1, 3'd4, 4'd9, 1, 3'd4, 0, "scan_entry_sel4");
    for (int i = 0; i < 5; i++)
      step(1, 1, 3'd4, 4'd9, 1, 3'd4, 0, "dwell9_hold");
    step(1, 1, 3'd4, 4'd2, 1, 3'd5, 0, "dwell_shrink_advance");
    step(1, 1, 3'd4, 4'd2, 1, 3'd5, 0, "after_shrink");

    // Mode toggle mid-dwell discards the count
    step(1, 0, 3'd3, 4'd2, 1, 3'd3, 0, "toggle_direct");
    step(1, 1, 3'd3, 4'd1, 1, 3'd3, 0, "reentry_sel3");
    step(1, 1, 3'd3, 4'd1, 1, 3'd3, 0, "reentry_hold");
    step(1, 1, 3'd3, 4'd1, 1, 3'd4, 0, "reentry_step");

`ifdef DECODER_SCAN_DIR_EN
    // Downward scan wraps on 0 -> 7; back to upward wraps on 7 -> 0
    dir_val = 1'b1;
    step(1, 0, 3'd1, 4'd0, 1, 3'd1, 0, "dir_direct_sel1");
    step(1, 1, 3'd1, 4'd0, 1, 3'd1, 0, "dir_entry_sel1");
    step(1, 1, 3'd1, 4'd0, 1, 3'd0, 0, "dir_down_0");
    step(1, 1, 3'd1, 4'd0, 1, 3'd7, 1, "dir_down_wrap7");
    dir_val = 1'b0;
    step(1, 1, 3'd1, 4'd0, 1, 3'd0, 1, "dir_up_wrap0");
    step(1, 1, 3'd1, 4'd0, 1, 3'd1, 0, "dir_up_1");
`endif

    // Asynchronous reset mid-scan, away from any clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset_mid_scan");
    #20;

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
